// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: memory/IO bus controller sitting behind the microcoded CPU.
// Serves one CPU request at a time against on-chip RAM, a read-only switch
// register and a read/write LED register. A fixed WAIT_CYC wait-state delay
// is inserted before the transfer. Completion is signalled by a one-cycle RDY.
// The controller then holds in HOLD until the CPU drops RD/WR, so a request
// level that stays high never issues a second access.
// Optional build macro MEM_BUS_ACCESS_CNT_EN adds an 8-bit access counter
// at address 8'hF2. Reads return the count; writes clear it.
module mem_bus_ctrl #(
  parameter int         RAM_DEPTH = 128,
  parameter int         WAIT_CYC  = 1,
  parameter logic [7:0] SW_ADDR   = 8'hF0,
  parameter logic [7:0] LED_ADDR  = 8'hF1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] MADDR,
  input  logic [7:0] DATA_W,
  input  logic       RD,
  input  logic       WR,
  output logic [7:0] DATA_R,
  output logic       RDY,
  output logic       BUSY,
  output logic       ERR,
  input  logic [7:0] SW,
  output logic [7:0] LED
);

  // RAM index width; a non-power-of-two depth still uses a power-of-two array
  // so that every index value is in range. Decode limits the real extent.
  localparam int         AW      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [8:0] RAM_END = 9'(RAM_DEPTH);
  localparam logic [4:0] WAIT_N  = 5'(WAIT_CYC);
`ifdef MEM_BUS_ACCESS_CNT_EN
  localparam logic [7:0] CNT_ADDR = 8'hF2;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
    S_DONE,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        is_wr_q, is_wr_d;
  logic [7:0]  data_r_q, data_r_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [7:0]  led_q, led_d;
  logic [7:0]  sw_meta_q, sw_meta_d;
  logic [7:0]  sw_sync_q, sw_sync_d;
`ifdef MEM_BUS_ACCESS_CNT_EN
  logic [7:0]  acc_q, acc_d;
`endif

  logic [7:0]  ram_q [2**AW];
  logic [AW-1:0] ram_idx;
  logic        sel_ram;
  logic        ram_we;
  logic [7:0]  rd_src;

  assign ram_idx   = addr_q[AW-1:0];
  assign sel_ram   = ({1'b0, addr_q} < RAM_END);
  assign sw_meta_d = SW;
  assign sw_sync_d = sw_meta_q;

  // Read-data decode of the latched address (RAM first, then I/O registers).
  always_comb begin
    rd_src = 8'h00;
    if (sel_ram) begin
      rd_src = ram_q[ram_idx];
    end else if (addr_q == SW_ADDR) begin
      rd_src = sw_sync_q;
    end else if (addr_q == LED_ADDR) begin
      rd_src = led_q;
`ifdef MEM_BUS_ACCESS_CNT_EN
    end else if (addr_q == CNT_ADDR) begin
      rd_src = acc_q;
`endif
    end
  end

  // Next-state logic and per-state register updates of the access sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    is_wr_d  = is_wr_q;
    data_r_d = data_r_q;
    rdy_d    = 1'b0;
    busy_d   = busy_q;
    err_d    = err_q;
    led_d    = led_q;
    ram_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (RD && WR) begin
          // Conflicting request: flag it and wait for the CPU to let go.
          err_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = S_HOLD;
        end else if (RD || WR) begin
          addr_d  = MADDR;
          wdata_d = DATA_W;
          is_wr_d = WR;
          busy_d  = 1'b1;
          cnt_d   = 4'd0;
          state_d = (WAIT_CYC > 0) ? S_WAIT : S_XFER;
        end
      end
      S_WAIT: begin
        if (({1'b0, cnt_q} + 5'd1) == WAIT_N) begin
          cnt_d   = 4'd0;
          state_d = S_XFER;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_XFER: begin
        if (is_wr_q) begin
          ram_we = sel_ram;
          if (!sel_ram && (addr_q == LED_ADDR)) begin
            led_d = wdata_q;
          end
        end else begin
          data_r_d = rd_src;
        end
        rdy_d   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!RD && !WR) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef MEM_BUS_ACCESS_CNT_EN
  // Access counter: a write to its address clears it at XFER, every DONE counts.
  always_comb begin
    acc_d = acc_q;
    if ((state_q == S_XFER) && is_wr_q && !sel_ram && (addr_q == CNT_ADDR)) begin
      acc_d = 8'h00;
    end else if (state_q == S_DONE) begin
      acc_d = acc_q + 8'h01;
    end
  end

  // Access counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  // Sequencer, request latch, outputs and switch synchronizer registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      is_wr_q   <= 1'b0;
      data_r_q  <= 8'h00;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      led_q     <= 8'h00;
      sw_meta_q <= 8'h00;
      sw_sync_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      is_wr_q   <= is_wr_d;
      data_r_q  <= data_r_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      led_q     <= led_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (ram_we) begin
      ram_q[ram_idx] <= wdata_q;
    end
  end

  assign DATA_R = data_r_q;
  assign RDY    = rdy_q;
  assign BUSY   = busy_q;
  assign ERR    = err_q;
  assign LED    = led_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl. Three instances with WAIT_CYC = 0, 1 and 3 share
// one stimulus stream. They are compared against a behavioural model of the
// memory map: a RAM array, the LED/switch values, the last read value and the
// optional access count.
module tb_mem_bus_ctrl;

  logic       CLK, RST;
  logic [7:0] MADDR, DATA_W, SW;
  logic       RD, WR;
  logic [7:0] data_r [3];
  logic [7:0] led    [3];
  logic [2:0] rdy, busy, err;

  int wc [3] = '{0, 1, 3};

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [7:0] mem_m   [256];
  bit         mem_v   [256];
  logic [7:0] led_m, sw_m, acc_m, last_rd_m;
  bit         last_v;

  mem_bus_ctrl #(.RAM_DEPTH(128), .WAIT_CYC(0)) u_w0 (
    .CLK(CLK), .RST(RST), .MADDR(MADDR), .DATA_W(DATA_W), .RD(RD), .WR(WR),
    .DATA_R(data_r[0]), .RDY(rdy[0]), .BUSY(busy[0]), .ERR(err[0]), .SW(SW), .LED(led[0]));
  mem_bus_ctrl #(.RAM_DEPTH(128), .WAIT_CYC(1)) u_w1 (
    .CLK(CLK), .RST(RST), .MADDR(MADDR), .DATA_W(DATA_W), .RD(RD), .WR(WR),
    .DATA_R(data_r[1]), .RDY(rdy[1]), .BUSY(busy[1]), .ERR(err[1]), .SW(SW), .LED(led[1]));
  mem_bus_ctrl #(.RAM_DEPTH(128), .WAIT_CYC(3)) u_w3 (
    .CLK(CLK), .RST(RST), .MADDR(MADDR), .DATA_W(DATA_W), .RD(RD), .WR(WR),
    .DATA_R(data_r[2]), .RDY(rdy[2]), .BUSY(busy[2]), .ERR(err[2]), .SW(SW), .LED(led[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic string tg(input string t, input int k);
    return $sformatf("%s[w%0d]", t, wc[k]);
  endfunction

  // Expected read value according to the address map.
  function automatic logic [7:0] model_rd(input logic [7:0] a, output bit known);
    known = 1'b1;
    if (a < 8'd128) begin
      known = mem_v[a];
      return mem_m[a];
    end
    if (a == 8'hF0) return sw_m;
    if (a == 8'hF1) return led_m;
`ifdef MEM_BUS_ACCESS_CNT_EN
    if (a == 8'hF2) return acc_m;
`endif
    return 8'h00;
  endfunction

  task automatic set_sw(input logic [7:0] v);
    @(negedge CLK);
    SW   = v;
    sw_m = v;
    repeat (3) @(posedge CLK);
  endtask

  task automatic model_reset();
    led_m     = 8'h00;
    acc_m     = 8'h00;
    last_rd_m = 8'h00;
    last_v    = 1'b1;
  endtask

  task automatic access(input bit is_wr, input logic [7:0] a, input logic [7:0] d);
    int  lat  [3];
    int  nrdy [3];
    bit  known;
    logic [7:0] exp;
    for (int k = 0; k < 3; k++) begin
      lat[k]  = 0;
      nrdy[k] = 0;
    end
    @(negedge CLK);
    MADDR  = a;
    DATA_W = d;
    WR     = is_wr;
    RD     = !is_wr;
    @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) chk(tg("busy_accept", k), busy[k], 1'b1);
    for (int n = 1; n <= 6; n++) begin
      @(posedge CLK);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (rdy[k] === 1'b1) begin
          nrdy[k]++;
          if (lat[k] == 0) lat[k] = n;
        end
      end
    end
    @(negedge CLK);
    RD = 1'b0;
    WR = 1'b0;
    @(posedge CLK);
    #1;
    // model update
    if (is_wr) begin
      if (a < 8'd128) begin
        mem_m[a] = d;
        mem_v[a] = 1'b1;
      end else if (a == 8'hF1) begin
        led_m = d;
      end
`ifdef MEM_BUS_ACCESS_CNT_EN
      else if (a == 8'hF2) acc_m = 8'h00;
`endif
    end else begin
      exp       = model_rd(a, known);
      last_rd_m = exp;
      last_v    = known;
    end
    acc_m = acc_m + 8'h01;
    for (int k = 0; k < 3; k++) begin
      chk(tg("latency", k), lat[k], wc[k] + 1);
      chk(tg("rdy_pulses", k), nrdy[k], 1);
      chk(tg("busy_release", k), busy[k], 1'b0);
      chk(tg("led", k), led[k], led_m);
      if (last_v) chk(tg($sformatf("data_r@%0h", a), k), data_r[k], last_rd_m);
    end
  endtask

  initial begin
    RST = 1'b1; RD = 1'b0; WR = 1'b0; MADDR = 8'h00; DATA_W = 8'h00; SW = 8'h00;
    sw_m = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem_m[i] = 8'h00;
      mem_v[i] = 1'b0;
    end
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // reset then idle
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK);
      #1;
      for (int k = 0; k < 3; k++)
        chk(tg("idle_state", k), {data_r[k], led[k], rdy[k], busy[k], err[k]}, 0);
    end

    // write then read back, level held across completion
    access(1'b1, 8'h10, 8'hA5);
    access(1'b1, 8'h20, 8'h5A);
    access(1'b0, 8'h10, 8'h00);
    access(1'b0, 8'h20, 8'h00);

    // I/O mapping
    access(1'b1, 8'hF1, 8'h3C);
    set_sw(8'h81);
    access(1'b0, 8'hF0, 8'h00);
    access(1'b1, 8'hF0, 8'h77);
    access(1'b0, 8'hF0, 8'h00);
    access(1'b0, 8'hF5, 8'h00);
    access(1'b0, 8'hF1, 8'h00);
    access(1'b1, 8'h80, 8'h99);
    access(1'b0, 8'h80, 8'h00);
    access(1'b0, 8'h7F, 8'h00);

    // access counter (reads as unmapped without the option)
    access(1'b0, 8'hF2, 8'h00);
    access(1'b1, 8'hF2, 8'h00);
    access(1'b0, 8'hF2, 8'h00);

    // randomized traffic over the whole map
    for (int t = 0; t < 40; t++) begin
      int         sel;
      logic [7:0] a;
      sel = int'($urandom_range(0, 4));
      case (sel)
        0, 1:    a = 8'($urandom_range(0, 31));
        2:       a = 8'hF0;
        3:       a = 8'hF1;
        default: a = 8'($urandom_range(128, 255));
      endcase
      if (a == 8'hF0) set_sw(8'($urandom));
      access(1'($urandom), a, 8'($urandom));
    end

    // reset in the middle of a write
    @(negedge CLK);
    MADDR = 8'h20; DATA_W = 8'hFF; WR = 1'b1; RD = 1'b0;
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk(tg("rst_busy", k), busy[k], 1'b0);
      chk(tg("rst_rdy", k), rdy[k], 1'b0);
      chk(tg("rst_data_r", k), data_r[k], 8'h00);
      chk(tg("rst_led", k), led[k], 8'h00);
    end
    @(negedge CLK);
    RST = 1'b0;
    WR  = 1'b0;
    model_reset();
    access(1'b0, 8'h20, 8'h00);

    // protocol error: both strobes high
    @(negedge CLK);
    MADDR = 8'h10; DATA_W = 8'h00; RD = 1'b1; WR = 1'b1;
    @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk(tg("err_set", k), err[k], 1'b1);
      chk(tg("err_busy", k), busy[k], 1'b1);
    end
    for (int n = 0; n < 5; n++) begin
      @(posedge CLK);
      #1;
      for (int k = 0; k < 3; k++) chk(tg("err_no_rdy", k), rdy[k], 1'b0);
    end
    @(negedge CLK);
    RD = 1'b0; WR = 1'b0;
    @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk(tg("err_busy_clr", k), busy[k], 1'b0);
      chk(tg("err_led", k), led[k], led_m);
    end
    access(1'b0, 8'h10, 8'h00);
    access(1'b1, 8'h30, 8'h42);
    for (int k = 0; k < 3; k++) chk(tg("err_sticky", k), err[k], 1'b1);

    // only reset clears ERR
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) chk(tg("err_clr", k), err[k], 1'b0);
    access(1'b0, 8'h30, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
